vga_scan_timing: RTL
====================

Name: vga_scan_timing

Overview:
- Upstream/downstream neighbour of the pixel fetch stage (GPU).
- Generates 640x480@60 raster counters (col/row) that drive the GPU's address generation.
- Receives the GPU's 12-bit pixel (vga_data) and drives the VGA connector: RGB444 plus hsync/vsync.
- Syncs are delay-matched to the fetch pipeline and blanking is enforced in both axes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DLY, 3, clocks from col/row change to matching vga_data (counter→vram_addr→BRAM→vga_data)
SYNC_POL, 0, active level of hsync/vsync (0 = negative polarity)

Ports:
clk  in  1  pixel clock, 25.175/25 MHz; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
col  out  10  horizontal counter hcnt, 0..H_TOTAL-1
row  out  9  vertical position; vcnt[8:0] when vcnt < V_ACTIVE, else 0
vga_data  in  12  pixel from GPU, {R[11:8],G[7:4],B[3:0]}
vga_r  out  4  red to DAC
vga_g  out  4  green to DAC
vga_b  out  4  blue to DAC
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_start  out  1  one-clock pulse when hcnt==0 and vcnt==0 (undelayed)

Behaviour:
- Reset is asynchronous and active-low; one clock domain, clk.
- Reset values:
  - hcnt = vcnt = 0; col = row = 0.
  - RGB = 0; hsync = vsync = !SYNC_POL (inactive); frame_start = 0.
  - All delay-line stages hold inactive sync and video_on = 0.
- Counting:
  - H_TOTAL = 800, V_TOTAL = 525.
  - hcnt increments every clock and wraps H_TOTAL-1 → 0.
  - vcnt increments only when hcnt wraps; it wraps V_TOTAL-1 → 0 on the same edge that hcnt wraps.
  - vcnt is 10 bits internally.
- Combinational raw controls from the counters:
  - video_on = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs_act = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_act = vcnt in [490, 491].
- col/row come straight from the counter registers (zero extra latency). row clamps to 0 during vertical blank because 9 bits cannot hold 480..524.
- Delay line: video_on, hs_act and vs_act pass through PIPE_DLY register stages.
- Output register, sampled on the same edge as the last delay stage:
  - {vga_r,vga_g,vga_b} = delayed video_on ? vga_data : 12'h000.
  - hsync = delayed hs_act ^ !SYNC_POL; vsync likewise from delayed vs_act.
- Total latency: counter value → pins = PIPE_DLY+1 clocks for all of RGB, hsync and vsync (mutually aligned).
- Blanking: RGB is forced to 0 whenever delayed video_on = 0, regardless of vga_data. This covers vertical blank, which the GPU does not blank.
- frame_start is registered; high for exactly one clock per frame, in the cycle where col==0 and row==0 with vcnt==0.
- Reset mid-frame: counters and outputs return to reset values immediately. After release, counting restarts at (0,0) and the first frame_start occurs on the first clock.
- PIPE_DLY == 0 is legal: the delay line degenerates to a wire.

Decomposition:
- Shared package vga_pkg: H_*/V_* defaults, H_TOTAL/V_TOTAL, HS_START/HS_END/VS_START/VS_END localparams, and an RGB444 field-slice constant.
- One sub-module, vga_sync_delay: parameterised-width (3), depth PIPE_DLY shift register with async active-low reset to a parameterised reset value.

Test Plan:
- Reset release, free-run 2 lines → col sequence 0..799,0; vcnt steps 0→1 exactly when col returns to 0; hsync low for 96 clocks, falling edge PIPE_DLY+1=4 clocks after col==656.
- Full frame → frame_start period exactly 420000 clocks; vsync low exactly 2×800=1600 clocks, beginning 4 clocks after (col,row-internal)=(0,490).
- Drive vga_data = 12'hF0A constantly → RGB = F,0,A only during 640×480 active region (shifted by 4 clocks), 0 at col=640..799 and during lines 480..524 even though vga_data is nonzero.
- Model GPU+BRAM as a 3-stage pipe returning {col[3:0],row[3:0],4'h5} → pixel on pins at active position (x,y) equals {x[3:0],y[3:0],5}; first visible pixel (0,0) matches.
- Vertical blank → row output holds 0 for vcnt 480..524 while col keeps counting.
- Assert rst_n low at (col=300,row=200) for 5 clocks → outputs go to reset values asynchronously (before next edge); after release col=0,row=0, frame_start=1 on first clock, and the next frame_start follows 420000 clocks later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and pixel layout for the VGA scan-out block.
// Default raster is 640x480@60 with negative sync polarity.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
    localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

    // GPU pixel word is {R[11:8], G[7:4], B[3:0]}
    localparam int RGB_BITS = 4;

    typedef struct packed {
        logic [RGB_BITS-1:0] r;
        logic [RGB_BITS-1:0] g;
        logic [RGB_BITS-1:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that delays the raw blanking/sync controls to line up
// with the pixel fetch pipeline; depth 0 degenerates to a wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_timing.sv
// Raster counters for the GPU fetch stage plus delay-matched, blanked
// RGB444/hsync/vsync drive for the VGA connector.
module vga_scan_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_DLY = 3,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  col,
    output logic [8:0]  row,
    input  logic [11:0] vga_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       running;
    logic       h_wrap;
    logic       v_wrap;
    logic [2:0] ctl_raw;
    logic [2:0] ctl_dly;
    rgb444_t    pix_q;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    // The first edge after reset only announces frame_start for the (0,0)
    // position already on col/row; counting starts on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            running     <= 1'b0;
            frame_start <= 1'b0;
        end else if (!running) begin
            running     <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            hcnt        <= h_wrap ? '0 : hcnt + 10'd1;
            if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 10'd1;
            frame_start <= h_wrap && v_wrap;
        end
    end

    assign col = hcnt;
    assign row = (vcnt < V_VIS) ? vcnt[8:0] : '0;

    assign ctl_raw = {(hcnt < H_VIS) && (vcnt < V_VIS),
                      (hcnt >= HS_LO) && (hcnt <= HS_HI),
                      (vcnt >= VS_LO) && (vcnt <= VS_HI)};

    vga_sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ctl_raw),
        .q     (ctl_dly)
    );

    // Vertical blank is not blanked by the GPU, so RGB is gated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            pix_q <= ctl_dly[2] ? rgb444_t'(vga_data) : '0;
            hsync <= ctl_dly[1] ^ ~SYNC_POL;
            vsync <= ctl_dly[0] ^ ~SYNC_POL;
        end
    end

    assign vga_r = pix_q.r;
    assign vga_g = pix_q.g;
    assign vga_b = pix_q.b;

endmodule
